// File: rtl/vtc_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// vtc_cfg_sequencer
//
// Boot-time AXI4-Lite master that programs the video timing controller's
// control port with a fixed seven-register timing set, turns the generator
// on, then reads the control register back to confirm the generator runs.
// Lets fixed-resolution builds bring up video without a CPU.
//
// Ports
//   aclk, aresetn          : clock (rising edge) and async active-low reset
//   start                  : one-cycle pulse, accepted in IDLE/DONE/ERROR
//   busy                   : a sequence is in flight
//   done / error           : sticky result levels, cleared by the next start
//   err_code               : 01 bad response, 10 timeout, 11 readback wrong
//   vtc_ctrl_aw*/w*/b*     : AXI4-Lite write channels toward the VTC
//   vtc_ctrl_ar*/r*        : AXI4-Lite read channels toward the VTC
// ---------------------------------------------------------------------------
module vtc_cfg_sequencer #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned HSYNC_START = 656,
  parameter int unsigned HSYNC_END   = 752,
  parameter int unsigned VSYNC_START = 490,
  parameter int unsigned VSYNC_END   = 492,
  parameter logic [31:0] POLARITY    = 32'h0000_0007,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [8:0]  vtc_ctrl_awaddr,
  output logic        vtc_ctrl_awvalid,
  input  logic        vtc_ctrl_awready,
  output logic [31:0] vtc_ctrl_wdata,
  output logic [3:0]  vtc_ctrl_wstrb,
  output logic        vtc_ctrl_wvalid,
  input  logic        vtc_ctrl_wready,
  input  logic [1:0]  vtc_ctrl_bresp,
  input  logic        vtc_ctrl_bvalid,
  output logic        vtc_ctrl_bready,
  output logic [8:0]  vtc_ctrl_araddr,
  output logic        vtc_ctrl_arvalid,
  input  logic        vtc_ctrl_arready,
  input  logic [31:0] vtc_ctrl_rdata,
  input  logic [1:0]  vtc_ctrl_rresp,
  input  logic        vtc_ctrl_rvalid,
  output logic        vtc_ctrl_rready
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  // Last count value still inside the allowed window; reaching it with the
  // phase unfinished means the slave has hung.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0]  LAST_IDX     = 3'd6;
  localparam logic [1:0]  CODE_RESP    = 2'b01;
  localparam logic [1:0]  CODE_TIMEOUT = 2'b10;
  localparam logic [1:0]  CODE_READBK  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE,
    ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [8:0]  awaddr_d;
  logic [31:0] wdata_d;
  logic        busy_d, done_d, error_d;
  logic [1:0]  err_code_d;
  logic        aw_left, w_left, timed_out;

  // Only the enable bits of the readback word matter.
  logic unused_rdata;
  assign unused_rdata = ^{vtc_ctrl_rdata[31:3], vtc_ctrl_rdata[1]};

  // Two 13-bit fields packed into the low and high halves of a register.
  function automatic logic [31:0] pack_pair(input logic [12:0] lo, input logic [12:0] hi);
    return {3'b000, hi, 3'b000, lo};
  endfunction

  // Register address for each step of the write list.
  function automatic logic [8:0] step_addr(input logic [2:0] i);
    case (i)
      3'd0:    return 9'h060;
      3'd1:    return 9'h06C;
      3'd2:    return 9'h070;
      3'd3:    return 9'h074;
      3'd4:    return 9'h078;
      3'd5:    return 9'h080;
      default: return 9'h000;
    endcase
  endfunction

  // Register value for each step; the last step sets SW_ENABLE, REG_UPDATE
  // and GEN_ENABLE in the control register.
  function automatic logic [31:0] step_data(input logic [2:0] i);
    case (i)
      3'd0:    return pack_pair(13'(H_ACTIVE), 13'(V_ACTIVE));
      3'd1:    return POLARITY;
      3'd2:    return {19'd0, 13'(H_TOTAL)};
      3'd3:    return {19'd0, 13'(V_TOTAL)};
      3'd4:    return pack_pair(13'(HSYNC_START), 13'(HSYNC_END));
      3'd5:    return pack_pair(13'(VSYNC_START), 13'(VSYNC_END));
      default: return 32'h0000_0007;
    endcase
  endfunction

  // The read address is always the control register and every write covers
  // all four byte lanes, so both are fixed.
  assign vtc_ctrl_araddr = 9'h000;
  assign vtc_ctrl_wstrb  = 4'hF;

  // A channel is still outstanding while its valid is up and the slave has
  // not yet accepted it on this edge.
  assign aw_left   = vtc_ctrl_awvalid & ~vtc_ctrl_awready;
  assign w_left    = vtc_ctrl_wvalid  & ~vtc_ctrl_wready;
  assign timed_out = (cnt_q == CNT_LAST);

  // Next-state and next-output logic. Every output is computed here for the
  // coming cycle and then registered, so the valid/ready lines change only
  // on clock edges. Normal progress wins over the timeout when both happen
  // on the same edge; entering ERROR leaves every valid/ready at its
  // default of zero, which is how a hung slave is abandoned.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    awvalid_d  = 1'b0;
    wvalid_d   = 1'b0;
    bready_d   = 1'b0;
    arvalid_d  = 1'b0;
    rready_d   = 1'b0;
    awaddr_d   = vtc_ctrl_awaddr;
    wdata_d    = vtc_ctrl_wdata;
    done_d     = done;
    error_d    = error;
    err_code_d = err_code;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = WR;
          idx_d      = 3'd0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'b00;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = step_addr(3'd0);
          wdata_d    = step_data(3'd0);
        end
      end

      WR: begin
        if (!aw_left && !w_left) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (timed_out) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_code_d = CODE_TIMEOUT;
        end else begin
          awvalid_d = aw_left;
          wvalid_d  = w_left;
        end
      end

      WR_RESP: begin
        if (vtc_ctrl_bvalid) begin
          if (vtc_ctrl_bresp != 2'b00) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = CODE_RESP;
          end else if (idx_q < LAST_IDX) begin
            state_d   = WR;
            idx_d     = idx_q + 3'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = step_addr(idx_q + 3'd1);
            wdata_d   = step_data(idx_q + 3'd1);
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else if (timed_out) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_code_d = CODE_TIMEOUT;
        end else begin
          bready_d = 1'b1;
        end
      end

      RD_ADDR: begin
        if (vtc_ctrl_arready) begin
          state_d  = RD_DATA;
          rready_d = 1'b1;
        end else if (timed_out) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_code_d = CODE_TIMEOUT;
        end else begin
          arvalid_d = 1'b1;
        end
      end

      RD_DATA: begin
        if (vtc_ctrl_rvalid) begin
          if (vtc_ctrl_rresp != 2'b00) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = CODE_RESP;
          end else if (!vtc_ctrl_rdata[0] || !vtc_ctrl_rdata[2]) begin
            state_d    = ERROR;
            error_d    = 1'b1;
            err_code_d = CODE_READBK;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (timed_out) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_code_d = CODE_TIMEOUT;
        end else begin
          rready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timeout counter: restarts on every state change so each handshake
  // phase gets its own budget, and only runs while a bus phase is pending.
  // busy follows the next state so it is a registered output too.
  always_comb begin
    busy_d = (state_d == WR) || (state_d == WR_RESP) ||
             (state_d == RD_ADDR) || (state_d == RD_DATA);
    cnt_d  = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State and output registers. Reset drops every valid/ready at once, so a
  // transfer interrupted by reset is simply forgotten.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= IDLE;
      idx_q            <= 3'd0;
      cnt_q            <= '0;
      vtc_ctrl_awvalid <= 1'b0;
      vtc_ctrl_wvalid  <= 1'b0;
      vtc_ctrl_bready  <= 1'b0;
      vtc_ctrl_arvalid <= 1'b0;
      vtc_ctrl_rready  <= 1'b0;
      vtc_ctrl_awaddr  <= 9'h000;
      vtc_ctrl_wdata   <= 32'h0000_0000;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      err_code         <= 2'b00;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      vtc_ctrl_awvalid <= awvalid_d;
      vtc_ctrl_wvalid  <= wvalid_d;
      vtc_ctrl_bready  <= bready_d;
      vtc_ctrl_arvalid <= arvalid_d;
      vtc_ctrl_rready  <= rready_d;
      vtc_ctrl_awaddr  <= awaddr_d;
      vtc_ctrl_wdata   <= wdata_d;
      busy             <= busy_d;
      done             <= done_d;
      error            <= error_d;
      err_code         <= err_code_d;
    end
  end

endmodule

// File: tb/tb_vtc_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vtc_cfg_sequencer
//
// Self-checking bench for vtc_cfg_sequencer. A small AXI4-Lite slave with
// configurable ready/response delays and error injection answers the DUT,
// logs accepted addresses/data and watches valid behaviour. A table of
// scenarios is run in order, followed by a hand-written reset sequence.
// ---------------------------------------------------------------------------
module tb_vtc_cfg_sequencer;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [8:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [8:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  vtc_cfg_sequencer dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_code         (err_code),
    .vtc_ctrl_awaddr  (awaddr),
    .vtc_ctrl_awvalid (awvalid),
    .vtc_ctrl_awready (awready),
    .vtc_ctrl_wdata   (wdata),
    .vtc_ctrl_wstrb   (wstrb),
    .vtc_ctrl_wvalid  (wvalid),
    .vtc_ctrl_wready  (wready),
    .vtc_ctrl_bresp   (bresp),
    .vtc_ctrl_bvalid  (bvalid),
    .vtc_ctrl_bready  (bready),
    .vtc_ctrl_araddr  (araddr),
    .vtc_ctrl_arvalid (arvalid),
    .vtc_ctrl_arready (arready),
    .vtc_ctrl_rdata   (rdata),
    .vtc_ctrl_rresp   (rresp),
    .vtc_ctrl_rvalid  (rvalid),
    .vtc_ctrl_rready  (rready)
  );

  // Free-running 10 ns clock.
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string       name;
    int          aw_delay;
    int          w_delay;
    int          b_delay;
    int          err_idx;
    bit          aw_never;
    logic [31:0] rd_value;
    logic [1:0]  rd_resp;
    int          pulse_cyc;
    int          exp_end;
    logic        exp_done;
    logic        exp_error;
    logic [1:0]  exp_code;
    int          exp_naw;
    int          exp_nw;
  } vec_t;

  localparam int LIMIT = 2000;

  logic [8:0]  exp_addr [7];
  logic [31:0] exp_data [7];
  vec_t        vecs [8];

  int vec_count  = 0;
  int miss_count = 0;

  // Slave configuration, written by the test between scenarios.
  int          cfg_aw_delay, cfg_w_delay, cfg_b_delay, cfg_err_idx;
  bit          cfg_aw_never;
  logic [31:0] cfg_rd_value;
  logic [1:0]  cfg_rd_resp;

  // Slave state and logs.
  logic [8:0]  aw_log [$];
  logic [31:0] w_log  [$];
  logic [8:0]  ar_log [$];
  int          proto_err;
  int          aw_cnt, w_cnt, b_wait, b_count;
  bit          aw_seen, w_seen, b_pending, r_pending;
  bit          prev_awvalid, prev_aw_fire, prev_wvalid, prev_w_fire;
  logic [8:0]  prev_awaddr;
  logic [31:0] prev_wdata;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearSlave();
    aw_log.delete();
    w_log.delete();
    ar_log.delete();
    proto_err = 0;
    aw_cnt    = 0;
    w_cnt     = 0;
    b_wait    = 0;
    b_count   = 0;
    aw_seen   = 0;
    w_seen    = 0;
    b_pending = 0;
    r_pending = 0;
  endtask

  // AXI4-Lite slave. Everything decided at a falling edge applies to the
  // following rising edge, and the DUT outputs read here are the values
  // that edge will sample. It also flags a valid that drops without a
  // handshake (other than into error), a valid that stays up after its
  // handshake, and address/data that change while valid is held.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    prev_awvalid = 0; prev_aw_fire = 0; prev_wvalid = 0; prev_w_fire = 0;
    prev_awaddr = 9'h0; prev_wdata = 32'h0;
    clearSlave();
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
        b_pending = 0; r_pending = 0;
        prev_awvalid = 0; prev_aw_fire = 0; prev_wvalid = 0; prev_w_fire = 0;
      end else begin
        if (prev_awvalid && !prev_aw_fire && !awvalid && !error) proto_err++;
        if (prev_aw_fire && awvalid) proto_err++;
        if (prev_awvalid && !prev_aw_fire && awvalid && awaddr !== prev_awaddr) proto_err++;
        if (prev_wvalid && !prev_w_fire && !wvalid && !error) proto_err++;
        if (prev_w_fire && wvalid) proto_err++;
        if (prev_wvalid && !prev_w_fire && wvalid && wdata !== prev_wdata) proto_err++;

        // Write response, held until bready is seen.
        bvalid = 1'b0;
        bresp  = 2'b00;
        if (b_pending) begin
          if (b_wait > 0) begin
            b_wait--;
          end else begin
            bvalid = 1'b1;
            bresp  = (b_count == cfg_err_idx) ? 2'b10 : 2'b00;
            if (bready) begin
              b_pending = 0;
              b_count++;
            end
          end
        end

        // Read data, one cycle after the address is taken.
        rvalid = 1'b0;
        rresp  = 2'b00;
        rdata  = 32'h0;
        if (r_pending) begin
          rvalid = 1'b1;
          rdata  = cfg_rd_value;
          rresp  = cfg_rd_resp;
          if (rready) r_pending = 0;
        end

        awready = awvalid && !cfg_aw_never && (aw_cnt >= cfg_aw_delay);
        prev_aw_fire = awvalid && awready;
        if (prev_aw_fire) begin
          aw_log.push_back(awaddr);
          aw_cnt  = 0;
          aw_seen = 1;
        end else if (awvalid) begin
          aw_cnt++;
        end

        wready = wvalid && (w_cnt >= cfg_w_delay);
        prev_w_fire = wvalid && wready;
        if (prev_w_fire) begin
          w_log.push_back(wdata);
          w_cnt  = 0;
          w_seen = 1;
        end else if (wvalid) begin
          w_cnt++;
        end

        if (aw_seen && w_seen) begin
          aw_seen   = 0;
          w_seen    = 0;
          b_pending = 1;
          b_wait    = cfg_b_delay;
        end

        arready = arvalid;
        if (arvalid) begin
          ar_log.push_back(araddr);
          r_pending = 1;
        end

        prev_awvalid = awvalid;
        prev_awaddr  = awaddr;
        prev_wvalid  = wvalid;
        prev_wdata   = wdata;
      end
    end
  end

  // Runs one scenario: configure the slave, pulse start, count cycles until
  // done or error, then check the result, the logged traffic and the quiet
  // bus afterwards.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    @(posedge aclk);
    #2;
    cfg_aw_delay = v.aw_delay;
    cfg_w_delay  = v.w_delay;
    cfg_b_delay  = v.b_delay;
    cfg_err_idx  = v.err_idx;
    cfg_aw_never = v.aw_never;
    cfg_rd_value = v.rd_value;
    cfg_rd_resp  = v.rd_resp;
    clearSlave();
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    cyc = 1;
    checkOutput({v.name, " busy at cycle 1"}, 32'(busy), 32'd1);
    checkOutput({v.name, " error cleared at cycle 1"}, 32'(error), 32'd0);
    checkOutput({v.name, " done cleared at cycle 1"}, 32'(done), 32'd0);
    while (!(done || error) && cyc < LIMIT) begin
      @(negedge aclk);
      cyc++;
      start = (cyc == v.pulse_cyc);
    end
    start = 1'b0;
    checkOutput({v.name, " end cycle"}, 32'(cyc), 32'(v.exp_end));
    checkOutput({v.name, " done"}, 32'(done), 32'(v.exp_done));
    checkOutput({v.name, " error"}, 32'(error), 32'(v.exp_error));
    checkOutput({v.name, " err_code"}, 32'(err_code), 32'(v.exp_code));
    checkOutput({v.name, " busy at end"}, 32'(busy), 32'd0);
    repeat (5) @(negedge aclk);
    checkOutput({v.name, " valids idle"}, 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    checkOutput({v.name, " AW count"}, 32'(aw_log.size()), 32'(v.exp_naw));
    checkOutput({v.name, " W count"}, 32'(w_log.size()), 32'(v.exp_nw));
    checkOutput({v.name, " AR count"}, 32'(ar_log.size()), (v.exp_naw == 7) ? 32'd1 : 32'd0);
    for (int i = 0; i < aw_log.size() && i < 7; i++)
      checkOutput($sformatf("%s awaddr[%0d]", v.name, i), 32'(aw_log[i]), 32'(exp_addr[i]));
    for (int i = 0; i < w_log.size() && i < 7; i++)
      checkOutput($sformatf("%s wdata[%0d]", v.name, i), w_log[i], exp_data[i]);
    for (int i = 0; i < ar_log.size(); i++)
      checkOutput($sformatf("%s araddr[%0d]", v.name, i), 32'(ar_log[i]), 32'h0);
    checkOutput({v.name, " valid protocol"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    exp_addr = '{9'h060, 9'h06C, 9'h070, 9'h074, 9'h078, 9'h080, 9'h000};
    exp_data = '{32'h01E0_0280, 32'h0000_0007, 32'h0000_0320, 32'h0000_020D,
                 32'h02F0_0290, 32'h01EC_01EA, 32'h0000_0007};

    //           name            aw w  b  err nev rdata  rresp pulse end done err code naw nw
    vecs[0] = '{"zero_wait",      0, 0, 0, -1, 0, 32'h7, 2'b00, 0, 17,  1'b1, 1'b0, 2'b00, 7, 7};
    vecs[1] = '{"w_before_aw",    3, 0, 5, -1, 0, 32'h7, 2'b00, 0, 73,  1'b1, 1'b0, 2'b00, 7, 7};
    vecs[2] = '{"bresp_idx3",     0, 0, 0,  3, 0, 32'h7, 2'b00, 0, 9,   1'b0, 1'b1, 2'b01, 4, 4};
    vecs[3] = '{"aw_timeout",     0, 0, 0, -1, 1, 32'h7, 2'b00, 0, 256, 1'b0, 1'b1, 2'b10, 0, 1};
    vecs[4] = '{"recover",        0, 0, 0, -1, 0, 32'h7, 2'b00, 0, 17,  1'b1, 1'b0, 2'b00, 7, 7};
    vecs[5] = '{"aw_before_w",    0, 2, 1, -1, 0, 32'h7, 2'b00, 0, 38,  1'b1, 1'b0, 2'b00, 7, 7};
    vecs[6] = '{"readback_bad",   0, 0, 0, -1, 0, 32'h3, 2'b00, 5, 17,  1'b0, 1'b1, 2'b11, 7, 7};
    vecs[7] = '{"rresp_err",      0, 0, 0, -1, 0, 32'h7, 2'b10, 0, 17,  1'b0, 1'b1, 2'b01, 7, 7};

    start   = 1'b0;
    aresetn = 1'b0;
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_b_delay = 0; cfg_err_idx = -1;
    cfg_aw_never = 0; cfg_rd_value = 32'h7; cfg_rd_resp = 2'b00;

    // Reset values while reset is held.
    repeat (2) @(negedge aclk);
    checkOutput("reset busy/done/error", 32'({busy, done, error}), 32'd0);
    checkOutput("reset err_code", 32'(err_code), 32'd0);
    checkOutput("reset valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    checkOutput("reset awaddr", 32'(awaddr), 32'd0);
    checkOutput("reset wdata", wdata, 32'd0);
    checkOutput("reset araddr", 32'(araddr), 32'd0);
    checkOutput("reset wstrb", 32'(wstrb), 32'hF);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("idle without start", 32'({busy, awvalid, wvalid}), 32'd0);

    for (int i = 0; i < 8; i++) begin
      $display("[TB] scenario %s", vecs[i].name);
      applyStimulus(vecs[i]);
    end

    // Reset dropped during the response phase of the third write.
    $display("[TB] scenario reset_mid_write");
    @(posedge aclk);
    #2;
    cfg_aw_delay = 0; cfg_w_delay = 0; cfg_b_delay = 0; cfg_err_idx = -1;
    cfg_aw_never = 0; cfg_rd_value = 32'h7; cfg_rd_resp = 2'b00;
    clearSlave();
    @(negedge aclk);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (5) @(negedge aclk);
    checkOutput("rst: bready in idx2 response", 32'(bready), 32'd1);
    checkOutput("rst: awaddr of idx2", 32'(awaddr), 32'h070);
    #1 aresetn = 1'b0;
    #1;
    checkOutput("rst: async busy/done/error", 32'({busy, done, error}), 32'd0);
    checkOutput("rst: async valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    checkOutput("rst: async awaddr", 32'(awaddr), 32'd0);
    checkOutput("rst: async wdata", wdata, 32'd0);
    checkOutput("rst: async err_code", 32'(err_code), 32'd0);
    @(negedge aclk);
    @(posedge aclk);
    #2 aresetn = 1'b1;
    clearSlave();
    repeat (10) @(negedge aclk);
    checkOutput("rst: stays idle", 32'({busy, done, error, awvalid, wvalid}), 32'd0);
    checkOutput("rst: no AW after release", 32'(aw_log.size()), 32'd0);
    applyStimulus(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
